// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the requesters/SRAM model and ram_port_arbiter.
// The master side drives the requests and the SRAM read data; the slave side is the arbiter.
interface ram_port_arbiter_if #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]              req_i;
    logic [NUM_PORTS-1:0]              gnt_o;
    logic [NUM_PORTS-1:0]              rvalid_o;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i;
    logic [NUM_PORTS-1:0]              we_i;
    logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i;
    logic [DATA_WIDTH-1:0]             rdata_o;
    logic                              ram_en_o;
    logic [ADDR_WIDTH-1:0]             ram_addr_o;
    logic                              ram_we_o;
    logic [DATA_WIDTH/8-1:0]           ram_be_o;
    logic [DATA_WIDTH-1:0]             ram_wdata_o;
    logic [DATA_WIDTH-1:0]             ram_rdata_i;

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, ram_rdata_i,
        output gnt_o, rvalid_o, rdata_o, ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
    );

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, ram_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Fixed-priority arbiter sharing one single-port SRAM among NUM_PORTS requesters (port 0 highest).
// Define RAM_ARB_STARVE_GUARD_EN to force a grant to any port p>0 denied MAX_WAIT cycles in a row.
module ram_port_arbiter #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 7
) (
    input logic               clk,
    input logic               rst_n,
    ram_port_arbiter_if.slave bus
);
    localparam int SelWidth = $clog2(NUM_PORTS);
    localparam int BeWidth  = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]  starved;
    logic [NUM_PORTS-1:0]  gntVec;
    logic [NUM_PORTS-1:0]  rvalid_d;
    logic [NUM_PORTS-1:0]  rvalid_q;
    logic [SelWidth-1:0]   sel;
    logic [ADDR_WIDTH-1:0] ramAddr;
    logic                  ramWe;
    logic [BeWidth-1:0]    ramBe;
    logic [DATA_WIDTH-1:0] ramWdata;

`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam int                  CntWidth = $clog2(MAX_WAIT + 1);
    localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MAX_WAIT);

    logic [CntWidth-1:0] waitCnt_q [1:NUM_PORTS-1];
    logic [CntWidth-1:0] waitCnt_d [1:NUM_PORTS-1];

    always_comb begin
        starved = '0;
        for (int p = 1; p < NUM_PORTS; p++) begin
            starved[p] = bus.req_i[p] && (waitCnt_q[p] == MaxCnt);
        end
    end

    // Counters saturate so a port blocked by a lower starved port stays eligible next cycle.
    always_comb begin
        for (int p = 1; p < NUM_PORTS; p++) begin
            waitCnt_d[p] = waitCnt_q[p];
            if (!bus.req_i[p] || gntVec[p]) begin
                waitCnt_d[p] = '0;
            end else if (waitCnt_q[p] != MaxCnt) begin
                waitCnt_d[p] = waitCnt_q[p] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 1; p < NUM_PORTS; p++) begin
                waitCnt_q[p] <= '0;
            end
        end else begin
            for (int p = 1; p < NUM_PORTS; p++) begin
                waitCnt_q[p] <= waitCnt_d[p];
            end
        end
    end
`else
    assign starved = '0;
`endif

    // Descending scans leave the lowest matching index in sel; a starved port overrides.
    always_comb begin
        sel = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (bus.req_i[p]) begin
                sel = SelWidth'(p);
            end
        end
        if (|starved) begin
            for (int p = NUM_PORTS - 1; p >= 1; p--) begin
                if (starved[p]) begin
                    sel = SelWidth'(p);
                end
            end
        end
    end

    always_comb begin
        gntVec   = '0;
        ramAddr  = bus.addr_i[0 +: ADDR_WIDTH];
        ramWe    = bus.we_i[0];
        ramBe    = bus.be_i[0 +: BeWidth];
        ramWdata = bus.wdata_i[0 +: DATA_WIDTH];
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sel == SelWidth'(p)) begin
                gntVec[p] = |bus.req_i;
                ramAddr   = bus.addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                ramWe     = bus.we_i[p];
                ramBe     = bus.be_i[p*BeWidth +: BeWidth];
                ramWdata  = bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rvalid_d = gntVec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.gnt_o       = gntVec;
    assign bus.rvalid_o    = rvalid_q;
    assign bus.rdata_o     = bus.ram_rdata_i;
    assign bus.ram_en_o    = |bus.req_i;
    assign bus.ram_addr_o  = ramAddr;
    assign bus.ram_we_o    = ramWe;
    assign bus.ram_be_o    = ramBe;
    assign bus.ram_wdata_o = ramWdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: vector table plus starvation and reset sequences.
// Expectations follow RAM_ARB_STARVE_GUARD_EN when the bench is built with it.
module tb_ram_port_arbiter;
    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 7;
`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam bit GuardEn = 1'b1;
`else
    localparam bit GuardEn = 1'b0;
`endif

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [2:0]  gnt;
        logic        en;
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } vec_t;

    logic clk;
    logic rst_n;
    int   vecCount;
    int   missCount;
    vec_t vecs [10];

    ram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busIf ();

    ram_port_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_WAIT  (MW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] req, input logic [2:0] we, input logic [31:0] rdata);
        busIf.req_i       = req;
        busIf.we_i        = we;
        busIf.ram_rdata_i = rdata;
    endtask

    function automatic logic [2:0] expPair(input int c);
        return (GuardEn && c == 8) ? 3'b010 : 3'b001;
    endfunction

    function automatic logic [2:0] expTriple(input int c);
        if (GuardEn && c == 8) return 3'b010;
        if (GuardEn && c == 9) return 3'b100;
        return 3'b001;
    endfunction

    initial begin
        vecCount  = 0;
        missCount = 0;
        // Port fields are fixed; port order in the packed buses is {p2, p1, p0}.
        busIf.addr_i  = {32'h0000_2000, 32'h0000_0040, 32'h0000_1000};
        busIf.be_i    = {4'b0011, 4'b1100, 4'b1111};
        busIf.wdata_i = {32'hDEAD_BEEF, 32'h1111_1111, 32'hCAFE_0000};
        //         req     we      gnt     en    addr           wr    be       wdata
        vecs[0] = '{3'b000, 3'b000, 3'b000, 1'b0, 32'h0000_1000, 1'b0, 4'b1111, 32'hCAFE_0000};
        vecs[1] = '{3'b010, 3'b000, 3'b010, 1'b1, 32'h0000_0040, 1'b0, 4'b1100, 32'h1111_1111};
        vecs[2] = '{3'b111, 3'b000, 3'b001, 1'b1, 32'h0000_1000, 1'b0, 4'b1111, 32'hCAFE_0000};
        vecs[3] = '{3'b100, 3'b100, 3'b100, 1'b1, 32'h0000_2000, 1'b1, 4'b0011, 32'hDEAD_BEEF};
        vecs[4] = '{3'b110, 3'b010, 3'b010, 1'b1, 32'h0000_0040, 1'b1, 4'b1100, 32'h1111_1111};
        vecs[5] = '{3'b101, 3'b001, 3'b001, 1'b1, 32'h0000_1000, 1'b1, 4'b1111, 32'hCAFE_0000};
        vecs[6] = '{3'b011, 3'b011, 3'b001, 1'b1, 32'h0000_1000, 1'b1, 4'b1111, 32'hCAFE_0000};
        vecs[7] = '{3'b000, 3'b111, 3'b000, 1'b0, 32'h0000_1000, 1'b1, 4'b1111, 32'hCAFE_0000};
        vecs[8] = '{3'b100, 3'b000, 3'b100, 1'b1, 32'h0000_2000, 1'b0, 4'b0011, 32'hDEAD_BEEF};
        vecs[9] = '{3'b100, 3'b000, 3'b100, 1'b1, 32'h0000_2000, 1'b0, 4'b0011, 32'hDEAD_BEEF};

        rst_n = 1'b0;
        applyStimulus(3'b000, 3'b000, 32'h0);
        #2;
        checkOutput("reset rvalid", 32'(busIf.rvalid_o), 32'h0);
        checkOutput("reset gnt", 32'(busIf.gnt_o), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].req, vecs[i].we, 32'hA5A5_0000 | 32'(i));
            #2;
            checkOutput($sformatf("v%0d gnt", i), 32'(busIf.gnt_o), 32'(vecs[i].gnt));
            checkOutput($sformatf("v%0d en", i), 32'(busIf.ram_en_o), 32'(vecs[i].en));
            checkOutput($sformatf("v%0d addr", i), busIf.ram_addr_o, vecs[i].addr);
            checkOutput($sformatf("v%0d we", i), 32'(busIf.ram_we_o), 32'(vecs[i].wr));
            checkOutput($sformatf("v%0d be", i), 32'(busIf.ram_be_o), 32'(vecs[i].be));
            checkOutput($sformatf("v%0d wdata", i), busIf.ram_wdata_o, vecs[i].wdata);
            checkOutput($sformatf("v%0d rdata", i), busIf.rdata_o, 32'hA5A5_0000 | 32'(i));
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d rvalid", i), 32'(busIf.rvalid_o), 32'(vecs[i].gnt));
        end

        // Ports 0 and 1 held: the guard forces port 1 on its eighth cycle.
        applyStimulus(3'b000, 3'b000, 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(3'b011, 3'b000, 32'h0);
        for (int c = 1; c <= 10; c++) begin
            #2;
            checkOutput($sformatf("pair c%0d gnt", c), 32'(busIf.gnt_o), 32'(expPair(c)));
            @(posedge clk);
            #1;
            checkOutput($sformatf("pair c%0d rvalid", c), 32'(busIf.rvalid_o), 32'(expPair(c)));
        end

        // All three held: ports 1 and 2 starve together and are served in index order.
        applyStimulus(3'b000, 3'b000, 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(3'b111, 3'b000, 32'h0);
        for (int c = 1; c <= 11; c++) begin
            #2;
            checkOutput($sformatf("triple c%0d gnt", c), 32'(busIf.gnt_o), 32'(expTriple(c)));
            @(posedge clk);
            #1;
            checkOutput($sformatf("triple c%0d rvalid", c), 32'(busIf.rvalid_o), 32'(expTriple(c)));
        end

        // Reset arriving while a second access is pending must drop that rvalid.
        applyStimulus(3'b000, 3'b000, 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(3'b010, 3'b000, 32'h0);
        #2;
        checkOutput("rst pre gnt", 32'(busIf.gnt_o), 32'h2);
        @(posedge clk);
        #1;
        checkOutput("rst pre rvalid", 32'(busIf.rvalid_o), 32'h2);
        rst_n = 1'b0;
        #1;
        checkOutput("rst async rvalid", 32'(busIf.rvalid_o), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rst held rvalid", 32'(busIf.rvalid_o), 32'h0);
        applyStimulus(3'b000, 3'b000, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        checkOutput("post rst gnt", 32'(busIf.gnt_o), 32'h0);
        checkOutput("post rst en", 32'(busIf.ram_en_o), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("post rst rvalid", 32'(busIf.rvalid_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
